// File: rtl/traffic_phase_fsm.sv
// Two-approach intersection phase sequencer: tick-prescaled phase timing,
// latched EW request, one-hot lamp vectors and one-hot downstream mux select.
module traffic_phase_fsm #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int RED_TICKS    = 1,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 ew_req,
    output logic [2:0]           ns_light,
    output logic [2:0]           ew_light,
    output logic [1:0]           sel,
    output logic [CNT_WIDTH-1:0] remain
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] G_LOAD = CNT_WIDTH'(GREEN_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] Y_LOAD = CNT_WIDTH'(YELLOW_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] R_LOAD = CNT_WIDTH'(RED_TICKS - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 req_latch_q, req_latch_d;
    logic [2:0]           ns_light_q, ns_light_d;
    logic [2:0]           ew_light_q, ew_light_d;
    logic [1:0]           sel_q, sel_d;
    logic                 expire;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_latch_d = req_latch_q | ew_req;
        expire      = tick && (cnt_q == '0);

        if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            NS_G: begin
                // NS green persists at counter 0 until some EW demand exists.
                if (expire && (req_latch_q || ew_req)) begin
                    state_d = NS_Y;
                    cnt_d   = Y_LOAD;
                end
            end
            NS_Y: if (expire) begin state_d = AR1;  cnt_d = R_LOAD; end
            AR1: begin
                if (expire) begin
                    state_d     = EW_G;
                    cnt_d       = G_LOAD;
                    req_latch_d = 1'b0;
                end
            end
            EW_G: if (expire) begin state_d = EW_Y; cnt_d = Y_LOAD; end
            EW_Y: if (expire) begin state_d = AR2;  cnt_d = R_LOAD; end
            AR2:  if (expire) begin state_d = NS_G; cnt_d = G_LOAD; end
            default: begin
                state_d = NS_G;
                cnt_d   = G_LOAD;
            end
        endcase

        // Lamps are registered from the next state so they track state_q exactly.
        case (state_d)
            NS_Y:    begin ns_light_d = 3'b010; ew_light_d = 3'b100; sel_d = 2'b01; end
            AR1:     begin ns_light_d = 3'b100; ew_light_d = 3'b100; sel_d = 2'b00; end
            EW_G:    begin ns_light_d = 3'b100; ew_light_d = 3'b001; sel_d = 2'b10; end
            EW_Y:    begin ns_light_d = 3'b100; ew_light_d = 3'b010; sel_d = 2'b10; end
            AR2:     begin ns_light_d = 3'b100; ew_light_d = 3'b100; sel_d = 2'b00; end
            default: begin ns_light_d = 3'b001; ew_light_d = 3'b100; sel_d = 2'b01; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= NS_G;
            cnt_q       <= G_LOAD;
            req_latch_q <= 1'b0;
            ns_light_q  <= 3'b001;
            ew_light_q  <= 3'b100;
            sel_q       <= 2'b01;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_latch_q <= req_latch_d;
            ns_light_q  <= ns_light_d;
            ew_light_q  <= ew_light_d;
            sel_q       <= sel_d;
        end
    end

    assign ns_light = ns_light_q;
    assign ew_light = ew_light_q;
    assign sel      = sel_q;
    assign remain   = cnt_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed bench for traffic_phase_fsm with GREEN=4, YELLOW=2, RED=1.
module tb_traffic_phase_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       ew_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [1:0] sel;
    logic [3:0] remain;

    int compared   = 0;
    int mismatched = 0;
    bit inv_en     = 1'b0;

    // {ns, ew, sel, remain} per cycle of one full 14-cycle period, tick every cycle.
    logic [11:0] exp_tab [14];
    logic [11:0] obs;
    logic [11:0] exp_v;

    traffic_phase_fsm #(
        .GREEN_TICKS (4),
        .YELLOW_TICKS(2),
        .RED_TICKS   (1),
        .CNT_WIDTH   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .ew_req  (ew_req),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .sel     (sel),
        .remain  (remain)
    );

    always #5 clk = ~clk;

    assign obs = {ns_light, ew_light, sel, remain};

    function automatic logic [11:0] pk(input logic [2:0] n, input logic [2:0] e,
                                       input logic [1:0] s, input int r);
        return {n, e, s, 4'(r)};
    endfunction

    task automatic build_table();
        int         dur [6];
        logic [2:0] nsl [6];
        logic [2:0] ewl [6];
        logic [1:0] sl  [6];
        int         idx;
        dur = '{4, 2, 1, 4, 2, 1};
        nsl = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
        ewl = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
        sl  = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        idx = 0;
        for (int p = 0; p < 6; p++) begin
            for (int j = 0; j < dur[p]; j++) begin
                exp_tab[idx] = pk(nsl[p], ewl[p], sl[p], dur[p] - 1 - j);
                idx++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Lamp/select invariants checked every cycle once reset has been applied.
    always @(negedge clk) begin
        if (inv_en) begin
            compared++;
            if (sel == 2'b11 || !$onehot(ns_light) || !$onehot(ew_light) ||
                !(ns_light[2] || ew_light[2]) ||
                ((sel == 2'b00) != (ns_light[2] && ew_light[2]))) begin
                mismatched++;
                $display("FAIL invariant t=%0t ns=%b ew=%b sel=%b", $time, ns_light, ew_light, sel);
            end
        end
    end

    task automatic test_reset();
        tick = 1'b1;
        ew_req = 1'b0;
        do_reset();
        inv_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_v = pk(3'b001, 3'b100, 2'b01, (i < 3) ? 3 - i : 0);
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, exp_v);
            end else $display("reset_hold cyc=%0d obs=%h ok", i, obs);
            step();
        end
    endtask

    task automatic test_full_cycle();
        tick = 1'b1;
        ew_req = 1'b1;
        do_reset();
        for (int i = 0; i < 28; i++) begin
            compared++;
            if (obs !== exp_tab[i % 14]) begin
                mismatched++;
                $display("FAIL full_cycle cyc=%0d got=%h want=%h", i, obs, exp_tab[i % 14]);
            end else $display("full_cycle cyc=%0d obs=%h ok", i, obs);
            step();
        end
        ew_req = 1'b0;
    endtask

    task automatic test_req_pulse();
        tick = 1'b1;
        ew_req = 1'b0;
        do_reset();
        ew_req = 1'b1;
        step();
        ew_req = 1'b0;
        for (int i = 1; i < 26; i++) begin
            exp_v = (i < 14) ? exp_tab[i] : pk(3'b001, 3'b100, 2'b01, (i < 17) ? 17 - i : 0);
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("FAIL req_pulse cyc=%0d got=%h want=%h", i, obs, exp_v);
            end else $display("req_pulse cyc=%0d obs=%h ok", i, obs);
            step();
        end
    endtask

    task automatic test_late_req();
        tick = 1'b1;
        ew_req = 1'b0;
        do_reset();
        repeat (5) step();
        compared++;
        if (obs !== exp_tab[3]) begin
            mismatched++;
            $display("FAIL late_req_hold got=%h want=%h", obs, exp_tab[3]);
        end else $display("late_req_hold obs=%h ok", obs);
        ew_req = 1'b1;
        step();
        ew_req = 1'b0;
        for (int i = 4; i < 7; i++) begin
            compared++;
            if (obs !== exp_tab[i]) begin
                mismatched++;
                $display("FAIL late_req cyc=%0d got=%h want=%h", i, obs, exp_tab[i]);
            end else $display("late_req cyc=%0d obs=%h ok", i, obs);
            step();
        end
    endtask

    task automatic test_slow_tick();
        ew_req = 1'b1;
        do_reset();
        for (int e = 1; e <= 42; e++) begin
            tick = ((e - 1) % 3 == 0);
            step();
            tick = 1'b0;
            exp_v = exp_tab[((e + 2) / 3) % 14];
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("FAIL slow_tick edge=%0d got=%h want=%h", e, obs, exp_v);
            end else $display("slow_tick edge=%0d obs=%h ok", e, obs);
        end
        ew_req = 1'b0;
    endtask

    task automatic test_reset_mid_phase();
        tick = 1'b1;
        ew_req = 1'b1;
        do_reset();
        repeat (11) step();
        compared++;
        if (obs !== exp_tab[11]) begin
            mismatched++;
            $display("FAIL mid_reset_pre got=%h want=%h", obs, exp_tab[11]);
        end else $display("mid_reset_pre obs=%h ok", obs);
        reset = 1'b1;
        step();
        reset = 1'b0;
        ew_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_v = pk(3'b001, 3'b100, 2'b01, (i < 3) ? 3 - i : 0);
            compared++;
            if (obs !== exp_v) begin
                mismatched++;
                $display("FAIL mid_reset cyc=%0d got=%h want=%h", i, obs, exp_v);
            end else $display("mid_reset cyc=%0d obs=%h ok", i, obs);
            step();
        end
    endtask

    initial begin
        build_table();
        test_reset();
        test_full_cycle();
        test_req_pulse();
        test_late_req();
        test_slow_tick();
        test_reset_mid_phase();
        inv_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
